// File: rtl/xrv_pkg.sv
// Shared RV32 definitions for the execute units and the decode stage.
package xrv_pkg;

  localparam int unsigned XLEN = 32;

  // Multiply group selector, encoded as funct3[1:0].
  typedef enum logic [1:0] {
    MUL_LO  = 2'd0,  // MUL    low half
    MUL_HSS = 2'd1,  // MULH   signed x signed, high half
    MUL_HSU = 2'd2,  // MULHSU signed x unsigned, high half
    MUL_HUU = 2'd3   // MULHU  unsigned x unsigned, high half
  } mul_op_e;

endpackage

// File: rtl/xrv_mul.sv
// Iterative radix-2 shift-add multiplier for the RV32M multiply group.
// Operands are reduced to magnitudes on issue, multiplied unsigned over 32
// iterations, and the sign is restored by a 64-bit negate on the output.
module xrv_mul
  import xrv_pkg::*;
(
  input  logic            clk,
  input  logic            rstb,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  input  logic [1:0]      optype,
  input  logic            valid,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  mul_op_e         op_in;
  logic            rs1_neg;
  logic            rs2_neg;
  logic [XLEN-1:0] rs1_abs;
  logic [XLEN-1:0] rs2_abs;

  logic [XLEN-1:0] mcand_reg;
  logic [XLEN-1:0] mplier_reg;
  logic [64:0]     prod;
  logic            sign_reg;
  mul_op_e         op_reg;
  logic [4:0]      cnt;

  logic [32:0]     upper_next;
  logic [63:0]     p64;

  assign op_in = mul_op_e'(optype);

  // Operand magnitudes; only signed operands with the sign bit set are negated.
  // |0x80000000| stays 0x80000000, which is exactly 2^31 read as unsigned.
  always_comb begin
    rs1_neg = (op_in != MUL_HUU) && multiplicand[XLEN-1];
    rs2_neg = ((op_in == MUL_LO) || (op_in == MUL_HSS)) && multiplier[XLEN-1];
    rs1_abs = rs1_neg ? (~multiplicand + 32'd1) : multiplicand;
    rs2_abs = rs2_neg ? (~multiplier + 32'd1) : multiplier;
  end

  // Conditional add of the multiplicand into the upper 33 bits of the product.
  always_comb begin
    upper_next = prod[64:32];
    if (mplier_reg[0]) begin
      upper_next = prod[64:32] + {1'b0, mcand_reg};
    end
  end

  // Sign correction and half selection of the final product.
  always_comb begin
    p64    = sign_reg ? (~prod[63:0] + 64'd1) : prod[63:0];
    result = (op_reg == MUL_LO) ? p64[31:0] : p64[63:32];
  end

  // Issue, iteration and completion control plus the shifting datapath.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      prod         <= '0;
      sign_reg     <= 1'b0;
      op_reg       <= MUL_LO;
      cnt          <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (valid) begin
        // A new issue always wins, silently aborting any operation in flight.
        mcand_reg  <= rs1_abs;
        mplier_reg <= rs2_abs;
        prod       <= '0;
        sign_reg   <= rs1_neg ^ rs2_neg;
        op_reg     <= op_in;
        cnt        <= '0;
        busy       <= 1'b1;
      end else if (busy) begin
        // Shift {prod, mplier_reg} right by one after the conditional add.
        prod       <= {1'b0, upper_next, prod[31:1]};
        mplier_reg <= {prod[0], mplier_reg[31:1]};
        cnt        <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          busy         <= 1'b0;
          result_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_xrv_mul.sv
// Directed self-checking bench for the iterative multiplier.
module tb_xrv_mul;

  logic        clk;
  logic        rstb;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [1:0]  optype;
  logic        valid;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;

  int errors = 0;
  int checks = 0;

  xrv_mul dut (
    .clk          (clk),
    .rstb         (rstb),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .optype       (optype),
    .valid        (valid),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle issue; returns at the falling edge right after the issue edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    optype       = op;
    multiplicand = a;
    multiplier   = b;
    valid        = 1'b1;
    @(negedge clk);
    valid        = 1'b0;
  endtask

  // Count falling edges until result_valid; lat = -1 if it never comes.
  task automatic wait_rv(output int lat, output int busy_cycles);
    lat         = -1;
    busy_cycles = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = k;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    valid = 1'b0;
    optype = 2'd0;
    multiplicand = '0;
    multiplier = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rv=%b result=%h, required 0 0 00000000",
               busy, result_valid, result);
    end
    repeat (2) @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bc;
    issue(2'd0, 32'd7, 32'd6);
    wait_rv(lat, bc);
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("FAIL basic_latency: got %0d, required 32", lat);
    end
    checks++;
    if (bc !== 32) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, required 32", bc);
    end
    checks++;
    if (result !== 32'h0000002A) begin
      errors++;
      $display("FAIL basic_result: got %h, required 0000002a", result);
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || result !== 32'h0000002A) begin
      errors++;
      $display("FAIL basic_pulse_hold: rv=%b result=%h, required 0 0000002a",
               result_valid, result);
    end
  endtask

  task automatic test_corners();
    logic [1:0]  ops [12];
    logic [31:0] as  [12];
    logic [31:0] bs  [12];
    logic [31:0] exp [12];
    int lat, bc;
    ops = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3};
    as  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
            32'h80000000, 32'hFFFFFFFD, 32'h00000000, 32'hFFFFFFFF};
    bs  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h80000000, 32'h80000000, 32'h00000001, 32'h80000000,
            32'hFFFFFFFF, 32'h00000005, 32'h12345678, 32'h00000002};
    exp = '{32'h00000001, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
            32'h40000000, 32'h00000000, 32'hFFFFFFFF, 32'h40000000,
            32'h80000000, 32'hFFFFFFF1, 32'h00000000, 32'h00000001};
    for (int i = 0; i < 12; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_rv(lat, bc);
      checks++;
      if (lat !== 32 || result !== exp[i]) begin
        errors++;
        $display("FAIL corner_%0d op=%0d %h*%h: result=%h lat=%0d, required %h lat=32",
                 i, ops[i], as[i], bs[i], result, lat, exp[i]);
      end
    end
  endtask

  task automatic test_restart();
    int lat, bc;
    int early;
    int extra;
    early = 0;
    extra = 0;
    issue(2'd0, 32'd100, 32'd100);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (result_valid) early++;
    end
    issue(2'd0, 32'd3, 32'd5);
    wait_rv(lat, bc);
    checks++;
    if (lat !== 32 || result !== 32'd15) begin
      errors++;
      $display("FAIL restart_result: result=%0d lat=%0d, required 15 lat=32", result, lat);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (result_valid) extra++;
    end
    checks++;
    if (early + extra !== 0) begin
      errors++;
      $display("FAIL restart_single_pulse: extra pulses=%0d, required 0", early + extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    issue(2'd0, 32'd9, 32'd11);
    wait_rv(lat, bc);
    checks++;
    if (lat !== 32 || result !== 32'd99) begin
      errors++;
      $display("FAIL b2b_first: result=%0d lat=%0d, required 99 lat=32", result, lat);
    end
    // Issue the next op during the result_valid cycle.
    optype       = 2'd3;
    multiplicand = 32'hFFFFFFFF;
    multiplier   = 32'hFFFFFFFF;
    valid        = 1'b1;
    @(negedge clk);
    valid        = 1'b0;
    wait_rv(lat, bc);
    checks++;
    if (lat !== 32 || result !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL b2b_second: result=%h lat=%0d, required fffffffe lat=32", result, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    int pulses;
    pulses = 0;
    issue(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (14) @(negedge clk);
    rstb = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_clear: busy=%b rv=%b result=%h, required 0 0 00000000",
               busy, result_valid, result);
    end
    @(negedge clk);
    rstb = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_pulse: pulses=%0d, required 0", pulses);
    end
    issue(2'd1, 32'hFFFFFFFD, 32'h00000005);
    wait_rv(lat, bc);
    checks++;
    if (lat !== 32 || result !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL reset_mid_recover: result=%h lat=%0d, required ffffffff lat=32",
               result, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
